ascon_bdi_packer: RTL
=====================

Name: ascon_bdi_packer

Overview:
- Upstream neighbour of the Ascon core's `bdi` input.
- Accepts a byte-wide, typed input stream and packs it into CCW-bit words with a contiguous byte-valid mask and `bdi_type`/`bdi_eot`/`bdi_eoi` side-band.
- The core treats `bdi_valid != 0` as "word present", so this block drives `bdi_valid` to zero whenever it holds no word.
- Two-register design (assembly + output) sustains one byte per cycle while the core stalls independently.

Parameters:
- CCW, 32: core data width in bits; legal values 32 and 64.
- CCWD8, CCW/8: bytes per word; derived, never overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- s_data  in  8  input byte.
- s_type  in  4  segment type, passed unchanged to `bdi_type`.
- s_valid  in  1  byte present.
- s_ready  out  1  byte accepted when `s_valid & s_ready`.
- s_last  in  1  byte is the last of its segment (end of type).
- s_eoi  in  1  byte is the last of all input; only meaningful with `s_last`.
- bdi  out  CCW  packed word; byte i in bits [8i+7:8i]; unused bytes zero.
- bdi_valid  out  CCWD8  byte mask, LSB-contiguous; all zero = no word.
- bdi_ready  in  1  core accepts the word when `(bdi_valid != 0) & bdi_ready`.
- bdi_type  out  4  type of the held word.
- bdi_eot  out  1  held word ends its segment.
- bdi_eoi  out  1  held word ends all input.
- err  out  1  sticky type-mismatch flag (optional feature only; tied 0 otherwise).

Behaviour:
- Assembly register: `asm_data`, `asm_cnt` (0..CCWD8), `asm_type`, `asm_last`, `asm_eoi`, `asm_sealed`.
- Output register: `bdi`, `bdi_valid`, `bdi_type`, `bdi_eot`, `bdi_eoi`; `out_full = (bdi_valid != 0)`.
- Assembly states:
  - EMPTY (`cnt == 0`): accepted byte writes lane 0, latches `s_type`, goes to PART. If `s_last` or CCWD8 == 1, goes to SEALED.
  - PART: accepted byte writes lane `cnt`, then `cnt++`. Reaching `cnt == CCWD8`, or accepting a byte with `s_last`, goes to SEALED and latches `last`/`eoi`.
  - SEALED: no bytes accepted unless a transfer occurs this cycle.
- Transfer: `xfer = asm_sealed & (!out_full | (out_full & bdi_ready))`.
  - On `xfer` the output register loads `asm_data`, mask = (1 << `asm_cnt`) - 1, type, `eot = asm_last`, `eoi = asm_eoi`.
  - Assembly restarts at `cnt = 0`; a byte accepted in the same cycle lands in lane 0 of the new word.
- `s_ready = !asm_sealed | xfer` (combinational). This gives full throughput: one CCWD8-byte word every CCWD8 cycles when `bdi_ready` is held high.
- Consume: `out_full & bdi_ready & !xfer` clears `bdi_valid`, `bdi`, `eot` and `eoi` to 0 on the next edge.
- Latency: a byte that seals a word at edge t is visible on `bdi` after edge t+1.
- Output holds stable while `out_full & !bdi_ready`; no change to any `bdi*` output.
- `s_eoi` without `s_last` is ignored. An `s_eoi` byte always seals.
- Zero-length segments are not representable; the core handles empty AD/message through `bdi_eoi` on the preceding segment.
- Reset, including mid-operation: discards both registers.
  - `bdi = 0`, `bdi_valid = 0`, `bdi_type = 0`, `bdi_eot = 0`, `bdi_eoi = 0`, `err = 0`.
  - `asm_cnt = 0`, `asm_sealed = 0`, so `s_ready = 1` in the first cycle after reset.

Optional Feature:
- Macro ASCON_BDI_PACKER_TYPECHK_EN.
- Defined: in PART, an accepted byte whose `s_type` differs from `asm_type` is dropped. `err` sets (sticky until `rst`), and the partial word is sealed with `eot = 1` so the core is never stalled.
- Undefined: type is taken from the first byte of each word, later `s_type` values are ignored, `err` is constant 0, and no check logic is generated.

Test Plan:
- CCW=32, type 1, bytes 11 22 33 44 55, `s_last` on 55, `bdi_ready = 1`:
  - word 0: `bdi = 32'h44332211`, mask 4'b1111, `eot = 0`.
  - word 1: `bdi = 32'h00000055`, mask 4'b0001, `eot = 1`.
- Back-to-back 12 bytes with `bdi_ready = 1` -> `s_ready` never drops, 3 words out, first word visible 5 cycles after the first byte is accepted.
- Hold `bdi_ready = 0` while 8 bytes are offered:
  - first word held stable; second word assembles, seals, `s_ready` goes 0.
  - on `bdi_ready = 1` both words emerge in order with no byte loss.
- Type 1 bytes AA BB (`last`), then type 2 byte CC (`last`, `eoi`) -> `{16'h0, BBAA}`, mask 0011, `eot = 1`; then `{24'h0, CC}`, mask 0001, type 2, `eot = 1`, `eoi = 1`.
- Assert `rst` for one cycle with a sealed word and a held word -> all outputs 0 and `s_ready = 1` next cycle; a subsequent byte DD with `last` emits `32'h000000DD`, mask 0001.
- With ASCON_BDI_PACKER_TYPECHK_EN: type 1 byte 01, then type 3 byte 02 -> `err = 1`, emitted `32'h00000001`, mask 0001, `eot = 1`; byte 02 is dropped.

Source files
------------

// File: rtl/ascon_bdi_packer.sv
// ascon_bdi_packer
//   Packs a byte-wide, typed input stream into CCW-bit words for the Ascon
//   core's bdi input. Each word carries an LSB-contiguous byte-valid mask and
//   type/eot/eoi side-band. The block has an assembly register and an output
//   register, so it accepts one byte per cycle while the core stalls on its
//   own schedule.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   s_data[7:0]     input byte
//   s_type[3:0]     segment type of the byte
//   s_valid/s_ready byte handshake (s_ready is combinational)
//   s_last          byte ends its segment
//   s_eoi           byte ends all input (only honoured together with s_last)
//   bdi[CCW-1:0]    packed word; byte i in bits [8i+7:8i]; unused bytes zero
//   bdi_valid       byte mask; all zero means no word is held
//   bdi_ready       core accepts the held word
//   bdi_type        type of the held word
//   bdi_eot/bdi_eoi held word ends its segment / all input
//   err             sticky type-mismatch flag
//
// Configuration
//   ASCON_BDI_PACKER_TYPECHK_EN: when defined, a byte whose type differs from
//   the word being assembled is dropped, err is set, and the partial word is
//   sealed with eot = 1. When undefined, the word takes its type from its
//   first byte and err is tied to 0.

module ascon_bdi_packer #(
    parameter  int CCW   = 32,
    localparam int CCWD8 = CCW / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_data,
    input  logic [3:0]       s_type,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_last,
    input  logic             s_eoi,
    output logic [CCW-1:0]   bdi,
    output logic [CCWD8-1:0] bdi_valid,
    input  logic             bdi_ready,
    output logic [3:0]       bdi_type,
    output logic             bdi_eot,
    output logic             bdi_eoi,
    output logic             err
);

    localparam int CNTW = $clog2(CCWD8 + 1);

    typedef enum logic [1:0] {
        EMPTY,
        PART,
        SEALED
    } asm_state_e;

    asm_state_e       asm_state_q;
    logic [CCW-1:0]   asm_data_q;
    logic [CNTW-1:0]  asm_cnt_q;
    logic [3:0]       asm_type_q;
    logic             asm_last_q;
    logic             asm_eoi_q;

    logic [CCW-1:0]   bdi_q;
    logic [CCWD8-1:0] bdi_valid_q;
    logic [3:0]       bdi_type_q;
    logic             bdi_eot_q;
    logic             bdi_eoi_q;

    logic             asm_sealed;
    logic             out_full;
    logic             xfer;
    logic             consume;
    logic             accept;
    logic             new_word;
    logic             type_bad;
    logic [CCWD8-1:0] xfer_mask;

    assign asm_sealed = (asm_state_q == SEALED);
    assign out_full   = |bdi_valid_q;
    assign xfer       = asm_sealed & (!out_full | bdi_ready);
    assign consume    = out_full & bdi_ready & !xfer;
    assign s_ready    = !asm_sealed | xfer;
    assign accept     = s_valid & s_ready;
    // A byte accepted while the sealed word moves out starts the next word.
    assign new_word   = xfer | (asm_state_q == EMPTY);

`ifdef ASCON_BDI_PACKER_TYPECHK_EN
    assign type_bad = accept & !new_word & (s_type != asm_type_q);
`else
    assign type_bad = 1'b0;
`endif

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        xfer_mask = '0;
        for (int i = 0; i < CCWD8; i++) begin
            xfer_mask[i] = (CNTW'(i) < asm_cnt_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_state_q <= EMPTY;
            asm_data_q  <= '0;
            asm_cnt_q   <= '0;
            asm_type_q  <= '0;
            asm_last_q  <= 1'b0;
            asm_eoi_q   <= 1'b0;
            bdi_q       <= '0;
            bdi_valid_q <= '0;
            bdi_type_q  <= '0;
            bdi_eot_q   <= 1'b0;
            bdi_eoi_q   <= 1'b0;
        end else begin
            // Assembly register. A transfer frees it; a byte accepted in the
            // same cycle overrides the restart below.
            if (xfer) begin
                asm_state_q <= EMPTY;
                asm_cnt_q   <= '0;
            end
            if (accept) begin
                if (new_word) begin
                    asm_data_q  <= {{(CCW-8){1'b0}}, s_data};
                    asm_cnt_q   <= CNTW'(1);
                    asm_type_q  <= s_type;
                    asm_last_q  <= s_last;
                    asm_eoi_q   <= s_last & s_eoi;
                    asm_state_q <= (s_last || CCWD8 == 1) ? SEALED : PART;
                end else if (type_bad) begin
                    // Drop the byte and close the partial word as a segment
                    // end so the core is never left waiting on it.
                    asm_last_q  <= 1'b1;
                    asm_eoi_q   <= 1'b0;
                    asm_state_q <= SEALED;
                end else begin
                    asm_data_q[8*asm_cnt_q +: 8] <= s_data;
                    asm_cnt_q   <= asm_cnt_q + CNTW'(1);
                    asm_last_q  <= s_last;
                    asm_eoi_q   <= s_last & s_eoi;
                    if (s_last || asm_cnt_q == CNTW'(CCWD8 - 1)) begin
                        asm_state_q <= SEALED;
                    end
                end
            end

            // Output register: load on transfer, clear on a plain consume,
            // otherwise hold every bdi* output unchanged.
            if (xfer) begin
                bdi_q       <= asm_data_q;
                bdi_valid_q <= xfer_mask;
                bdi_type_q  <= asm_type_q;
                bdi_eot_q   <= asm_last_q;
                bdi_eoi_q   <= asm_eoi_q;
            end else if (consume) begin
                bdi_q       <= '0;
                bdi_valid_q <= '0;
                bdi_eot_q   <= 1'b0;
                bdi_eoi_q   <= 1'b0;
            end
        end
    end

`ifdef ASCON_BDI_PACKER_TYPECHK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (type_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign bdi       = bdi_q;
    assign bdi_valid = bdi_valid_q;
    assign bdi_type  = bdi_type_q;
    assign bdi_eot   = bdi_eot_q;
    assign bdi_eoi   = bdi_eoi_q;

endmodule
